// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_pkg
// Description : Shared types and constants for the multi-port main store.
//               Holds the access FSM state encoding, default geometry and
//               latency, and small helpers for channel-slice arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_pkg;

    localparam int c_DEFAULT_DATA_WIDTH    = 31;
    localparam int c_DEFAULT_ADDR_WIDTH    = 12;
    localparam int c_DEFAULT_CHANNELS      = 2;
    localparam int c_DEFAULT_ACCESS_CYCLES = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Base bit index of channel ch inside a flattened per-channel bus.
    function automatic int chan_base(input int ch, input int width);
        return ch * width;
    endfunction

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : memory_pkg
`default_nettype wire

// File: rtl/round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_arbiter
// Description : Combinational round-robin selector. Picks the lowest pending
//               channel index at or after rr_ptr, wrapping circularly.
// Ports       : pending      - per-channel request-pending vector
//               rr_ptr       - channel with highest priority this round
//               grant_valid  - at least one channel is pending
//               grant_idx    - index of the selected channel
//               grant_onehot - one-hot form of grant_idx (zero if no grant)
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_arbiter
    import memory_pkg::*;
#(
    parameter int CHANNELS = c_DEFAULT_CHANNELS,
    parameter int PTR_W    = ptr_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] pending,
    input  logic [PTR_W-1:0]    rr_ptr,
    output logic                grant_valid,
    output logic [PTR_W-1:0]    grant_idx,
    output logic [CHANNELS-1:0] grant_onehot
);

    localparam logic [PTR_W:0] c_CHAN = (PTR_W + 1)'(CHANNELS);

    logic [PTR_W:0] w_pos;

    // Scan offsets from farthest to nearest so the closest pending channel
    // (smallest offset from rr_ptr) is the last assignment and wins.
    always_comb begin
        w_pos        = '0;
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            w_pos = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (w_pos >= c_CHAN) begin
                w_pos = w_pos - c_CHAN;
            end
            if (pending[w_pos[PTR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = w_pos[PTR_W-1:0];
            end
        end
        if (grant_valid) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule : round_robin_arbiter
`default_nettype wire

// File: rtl/multi_port_memory.sv
`default_nettype none
// ============================================================================
// Module      : multi_port_memory
// Description : Word-addressed RAM shared by several requesters. Each channel
//               latches one request at a time; a round-robin arbiter picks
//               the next channel and every access occupies ACCESS_CYCLES
//               cycles before it commits, emulating core-store timing.
// Ports       : clk          - rising-edge clock
//               reset        - synchronous active-high reset
//               write_enable - per-channel write request pulse
//               read_enable  - per-channel read request pulse
//               addr         - per-channel address, flattened
//               write_data   - per-channel write word, flattened
//               finish       - per-channel idle flag (low while pending)
//               read_data    - per-channel last read word, flattened
// Revision    : 1.0 - initial release
// ============================================================================
module multi_port_memory
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH    = c_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH    = c_DEFAULT_ADDR_WIDTH,
    parameter int CHANNELS      = c_DEFAULT_CHANNELS,
    parameter int ACCESS_CYCLES = c_DEFAULT_ACCESS_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            write_enable,
    input  logic [CHANNELS-1:0]            read_enable,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] write_data,
    output logic [CHANNELS-1:0]            finish,
    output logic [CHANNELS*DATA_WIDTH-1:0] read_data
);

    localparam int                 c_PTR_W    = ptr_width(CHANNELS);
    localparam int                 c_CNT_W    = ptr_width(ACCESS_CYCLES);
    localparam int                 c_DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [c_PTR_W-1:0] c_LAST_CH  = c_PTR_W'(CHANNELS - 1);

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_PTR_W-1:0]    r_rr_ptr;
    logic [c_PTR_W-1:0]    r_grant_idx;
    logic [CHANNELS-1:0]   r_grant_oh;
    logic [CHANNELS-1:0]   r_pending;
    logic [CHANNELS-1:0]   r_ch_wr;
    logic [CHANNELS-1:0]   r_ch_rd;
    logic [ADDR_WIDTH-1:0] r_ch_addr [CHANNELS];
    logic [DATA_WIDTH-1:0] r_ch_data [CHANNELS];
    logic [DATA_WIDTH-1:0] r_rd_data [CHANNELS];
    logic [DATA_WIDTH-1:0] r_mem     [c_DEPTH];

    logic                  w_arb_valid;
    logic [c_PTR_W-1:0]    w_arb_idx;
    logic [CHANNELS-1:0]   w_arb_oh;
    logic                  w_commit;
    logic [CHANNELS-1:0]   w_pend_set;
    logic [CHANNELS-1:0]   w_pend_clr;

    round_robin_arbiter #(
        .CHANNELS (CHANNELS),
        .PTR_W    (c_PTR_W)
    ) u_arbiter (
        .pending      (r_pending),
        .rr_ptr       (r_rr_ptr),
        .grant_valid  (w_arb_valid),
        .grant_idx    (w_arb_idx),
        .grant_onehot (w_arb_oh)
    );

    // Final ACCESS edge. Gated by reset so an access interrupted exactly on
    // its commit edge never reaches the array.
    assign w_commit   = (r_state == ST_ACCESS) && (r_cnt == '0) && !reset;
    // A busy channel ignores new pulses, including on its own commit edge.
    assign w_pend_set = (write_enable | read_enable) & ~r_pending;
    assign w_pend_clr = w_commit ? r_grant_oh : '0;
    assign finish     = ~r_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_grant_oh  <= '0;
            r_pending   <= '0;
            r_ch_wr     <= '0;
            r_ch_rd     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_ch_addr[i] <= '0;
                r_ch_data[i] <= '0;
                r_rd_data[i] <= '0;
            end
        end else begin
            r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_pend_set[i]) begin
                    r_ch_wr[i]   <= write_enable[i];
                    r_ch_rd[i]   <= read_enable[i];
                    r_ch_addr[i] <= addr[chan_base(i, ADDR_WIDTH) +: ADDR_WIDTH];
                    r_ch_data[i] <= write_data[chan_base(i, DATA_WIDTH) +: DATA_WIDTH];
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant_idx <= w_arb_idx;
                        r_grant_oh  <= w_arb_oh;
                        r_cnt       <= c_CNT_LOAD;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Read-with-write returns the written word directly.
                        if (r_ch_rd[r_grant_idx]) begin
                            r_rd_data[r_grant_idx] <= r_ch_wr[r_grant_idx]
                                                    ? r_ch_data[r_grant_idx]
                                                    : r_mem[r_ch_addr[r_grant_idx]];
                        end
                        r_rr_ptr <= (r_grant_idx == c_LAST_CH) ? '0
                                                                : r_grant_idx + 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Storage array: single write port, contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_commit && r_ch_wr[r_grant_idx]) begin
            r_mem[r_ch_addr[r_grant_idx]] <= r_ch_data[r_grant_idx];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_rd_out
        assign read_data[chan_base(g, DATA_WIDTH) +: DATA_WIDTH] = r_rd_data[g];
    end

endmodule : multi_port_memory
`default_nettype wire

// File: tb/tb_multi_port_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_port_memory
// Description : Self-checking bench for multi_port_memory: a table of
//               single-channel operations, hand-written contention, fairness,
//               re-request and reset sequences, and randomized two-channel
//               rounds checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_port_memory;

    localparam int DW  = 31;
    localparam int AW  = 12;
    localparam int CH  = 2;
    localparam int AC  = 4;
    localparam int LOW = AC + 1;   // cycles finish stays low per access

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [CH-1:0]     write_enable = '0;
    logic [CH-1:0]     read_enable  = '0;
    logic [CH*AW-1:0]  addr         = '0;
    logic [CH*DW-1:0]  write_data   = '0;
    logic [CH-1:0]     finish;
    logic [CH*DW-1:0]  read_data;

    int n_checks = 0;
    int n_errors = 0;

    multi_port_memory #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .CHANNELS      (CH),
        .ACCESS_CYCLES (AC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .addr         (addr),
        .write_data   (write_data),
        .finish       (finish),
        .read_data    (read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            ch;
        bit            we;
        bit            re;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
    } vec_t;

    // Behavioural model state for the randomized section.
    logic [DW-1:0] m_mem [logic [AW-1:0]];
    logic [DW-1:0] m_rd  [CH];
    int            m_next;   // channel favoured for the next simultaneous grant

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'o%0o, expected 'o%0o", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input bit we, input bit re,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_enable[ch]       = we;
        read_enable[ch]        = re;
        addr[ch*AW +: AW]      = a;
        write_data[ch*DW +: DW] = d;
    endtask

    task automatic launch();
        tick();
        write_enable = '0;
        read_enable  = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] rd(input int ch);
        return read_data[ch*DW +: DW];
    endfunction

    // Cycles from the request edge until finish[ch] is seen high again.
    task automatic wait_done(input int ch, output int n);
        n = 0;
        while (!finish[ch] && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   n;

        vecs[0] = '{0, 1'b1, 1'b0, 12'o1234, 31'o12345670123, 31'o0};
        vecs[1] = '{0, 1'b0, 1'b1, 12'o1234, 31'o0,           31'o12345670123};
        vecs[2] = '{1, 1'b1, 1'b1, 12'o7777, 31'o17777777777, 31'o17777777777};
        vecs[3] = '{0, 1'b0, 1'b1, 12'o7777, 31'o0,           31'o17777777777};
        vecs[4] = '{1, 1'b1, 1'b0, 12'o0100, 31'o11,          31'o17777777777};
        vecs[5] = '{1, 1'b0, 1'b1, 12'o0100, 31'o0,           31'o11};

        // ---------------- reset state ----------------
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset finish", finish, 2'b11);
        check("reset read_data", read_data, '0);

        // ---------------- table of single-channel operations ----------------
        for (int v = 0; v < 6; v++) begin
            set_req(vecs[v].ch, vecs[v].we, vecs[v].re, vecs[v].a, vecs[v].d);
            launch();
            wait_done(vecs[v].ch, n);
            check($sformatf("vec%0d finish-low cycles", v), n, LOW);
            check($sformatf("vec%0d read_data", v), rd(vecs[v].ch), vecs[v].exp_rd);
        end

        // ---------------- contention ----------------
        begin
            int t, t0, t1;
            pulse_reset();
            set_req(0, 1'b1, 1'b0, 12'o0007, 31'o77);
            set_req(1, 1'b0, 1'b1, 12'o0007, 31'o0);
            launch();
            t = 0; t0 = -1; t1 = -1;
            while ((t0 < 0 || t1 < 0) && t < 100) begin
                tick();
                t++;
                if (finish[0] && t0 < 0) t0 = t;
                if (finish[1] && t1 < 0) t1 = t;
            end
            check("contention ch0 finish time", t0, LOW);
            check("contention ch1 finish time", t1, 2 * LOW);
            check("contention ch1 read_data", rd(1), 31'o77);
        end

        // ---------------- fairness ----------------
        begin
            int            order[$];
            int            issued[CH];
            int            t;
            logic [CH-1:0] prev;
            issued = '{0, 0};
            t = 0;
            while (order.size() < 16 && t < 400) begin
                for (int c = 0; c < CH; c++) begin
                    if (finish[c] && issued[c] < 8) begin
                        set_req(c, 1'b0, 1'b1, 12'o0007, 31'o0);
                        issued[c]++;
                    end
                end
                prev = finish;
                launch();
                t++;
                for (int c = 0; c < CH; c++) begin
                    if (!prev[c] && finish[c]) order.push_back(c);
                end
            end
            check("fairness completions", order.size(), 16);
            for (int k = 0; k < order.size(); k++) begin
                check($sformatf("fairness grant %0d", k), order[k], k % 2);
            end
            check("fairness ch0 read_data", rd(0), 31'o77);
            check("fairness ch1 read_data", rd(1), 31'o77);
        end

        // ---------------- ignored re-request ----------------
        begin
            int highs;
            set_req(0, 1'b0, 1'b1, 12'o1234, 31'o0);
            launch();
            n = 0;
            while (!finish[0] && n < 20) begin
                // Second pulse mid-access and a third on the completion edge.
                if (n == 1 || n == 4) set_req(0, 1'b0, 1'b1, 12'o7777, 31'o0);
                launch();
                n++;
            end
            check("rereq finish-low cycles", n, LOW);
            check("rereq read_data", rd(0), 31'o12345670123);
            highs = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (finish[0]) highs++;
            end
            check("rereq no second access", highs, 10);
        end

        // ---------------- reset mid-access ----------------
        set_req(1, 1'b1, 1'b0, 12'o0100, 31'o55);
        launch();
        tick();
        tick();
        tick();
        reset = 1'b1;          // sampled on the edge ending the 3rd ACCESS cycle
        tick();
        reset = 1'b0;
        check("midreset finish", finish, 2'b11);
        check("midreset read_data", read_data, '0);
        set_req(0, 1'b0, 1'b1, 12'o0100, 31'o0);
        launch();
        wait_done(0, n);
        check("midreset finish-low cycles", n, LOW);
        check("midreset old word kept", rd(0), 31'o11);

        // ---------------- randomized rounds vs model ----------------
        begin
            logic [AW-1:0] pool [4];
            int            op   [CH];
            logic [AW-1:0] ra   [CH];
            logic [DW-1:0] rdv  [CH];
            int            exp_t[CH];
            int            got_t[CH];
            int            serve[$];
            int            t;
            bit            busy;

            pulse_reset();
            m_rd   = '{'0, '0};
            m_next = 0;
            for (int p = 0; p < 4; p++) begin
                pool[p] = AW'($urandom_range(0, 2 ** AW - 1));
                rdv[0]  = DW'($urandom);
                set_req(0, 1'b1, 1'b0, pool[p], rdv[0]);
                m_mem[pool[p]] = rdv[0];
                m_next = 1;
                launch();
                wait_done(0, n);
                check($sformatf("prefill%0d finish-low cycles", p), n, LOW);
            end

            for (int r = 0; r < 40; r++) begin
                for (int c = 0; c < CH; c++) begin
                    op[c]  = $urandom_range(0, 3);   // 0 none, 1 wr, 2 rd, 3 wr+rd
                    ra[c]  = pool[$urandom_range(0, 3)];
                    rdv[c] = DW'($urandom);
                end
                if (op[0] == 0 && op[1] == 0) op[0] = 2;

                // Model: service order starts at the favoured channel.
                serve.delete();
                for (int k = 0; k < CH; k++) begin
                    if (op[(m_next + k) % CH] != 0) serve.push_back((m_next + k) % CH);
                end
                exp_t = '{-1, -1};
                for (int k = 0; k < serve.size(); k++) begin
                    int c;
                    c = serve[k];
                    exp_t[c] = LOW * (k + 1);
                    if (op[c] == 1 || op[c] == 3) m_mem[ra[c]] = rdv[c];
                    if (op[c] == 3)      m_rd[c] = rdv[c];
                    else if (op[c] == 2) m_rd[c] = m_mem[ra[c]];
                    m_next = (c + 1) % CH;
                end

                for (int c = 0; c < CH; c++) begin
                    set_req(c, op[c] == 1 || op[c] == 3, op[c] == 2 || op[c] == 3, ra[c], rdv[c]);
                end
                launch();
                got_t = '{-1, -1};
                for (int c = 0; c < CH; c++) if (op[c] != 0 && finish[c]) got_t[c] = 0;
                t = 0;
                busy = 1'b1;
                while (busy && t < 100) begin
                    tick();
                    t++;
                    busy = 1'b0;
                    for (int c = 0; c < CH; c++) begin
                        if (op[c] != 0 && got_t[c] < 0) begin
                            if (finish[c]) got_t[c] = t;
                            else           busy = 1'b1;
                        end
                    end
                end
                for (int c = 0; c < CH; c++) begin
                    if (op[c] != 0) check($sformatf("rand%0d ch%0d finish time", r, c), got_t[c], exp_t[c]);
                    check($sformatf("rand%0d ch%0d read_data", r, c), rd(c), m_rd[c]);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_multi_port_memory
`default_nettype wire
